// File: rtl/es_ctrl_if.sv
// CPU/peripheral-side signal bundle for the es_ctrl I/O transfer controller.
interface es_ctrl_if;
  logic       io_rd;
  logic       io_wr;
  logic [1:0] io_id;
  logic [3:0] in_valid;
  logic [3:0] out_ready;
  logic [3:0] in_ack;
  logic [1:0] id_in;
  logic [1:0] id_out;
  logic [3:0] rwe;
  logic       stall;
  logic       io_done;
  logic       io_err;
  logic       pend;
  logic [1:0] pend_id;

  modport master (
    output io_rd, io_wr, io_id, in_valid, out_ready,
    input  in_ack, id_in, id_out, rwe, stall, io_done, io_err, pend, pend_id
  );

  modport slave (
    input  io_rd, io_wr, io_id, in_valid, out_ready,
    output in_ack, id_in, id_out, rwe, stall, io_done, io_err, pend, pend_id
  );
endinterface

// File: rtl/es_ctrl.sv
// I/O transfer controller: sequences 4-in/4-out port handshakes and stalls the CPU.
// Optional handshake timeout enabled by defining ES_CTRL_TIMEOUT_EN.
// states: IDLE wait for request | RD_WAIT await in_valid | WR_WAIT await out_ready | DONE pulse io_done
module es_ctrl #(
  parameter int TIMEOUT_W = 8
) (
  input  logic     clk,
  input  logic     reset,
  es_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t     state;
  logic [1:0] cur_id;
  logic [1:0] rr;
  logic       is_rd;
  logic       done_q;
  logic [3:0] ack_q;
  logic [3:0] rwe_q;
  logic [1:0] id_q;
  logic       pend_q;
  logic [1:0] pend_id_q;
  logic       err_q;

  // Width guard; the parameter only sizes the optional timeout counter.
  if (TIMEOUT_W < 1) begin : g_bad_timeout_w
  end

  // First set bit of v scanning p, p+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (v[idx]) rr_pick = idx;
    end
  endfunction

`ifdef ES_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt;
  logic [TIMEOUT_W-1:0] to_nxt;
  assign to_nxt = to_cnt + TIMEOUT_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_id    <= 2'd0;
      rr        <= 2'd0;
      is_rd     <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 4'd0;
      rwe_q     <= 4'd0;
      id_q      <= 2'd0;
      pend_q    <= 1'b0;
      pend_id_q <= 2'd0;
      err_q     <= 1'b0;
`ifdef ES_CTRL_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      ack_q     <= 4'd0;
      rwe_q     <= 4'd0;
      err_q     <= 1'b0;
      pend_q    <= |bus.in_valid;
      pend_id_q <= rr_pick(bus.in_valid, rr);
      case (state)
        IDLE: begin
          if (bus.io_rd || bus.io_wr) begin
            cur_id <= bus.io_id;
            id_q   <= bus.io_id;
            is_rd  <= bus.io_rd;
            state  <= bus.io_rd ? RD_WAIT : WR_WAIT;
`ifdef ES_CTRL_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end
        RD_WAIT: begin
          if (bus.in_valid[cur_id]) begin
            state  <= DONE;
            done_q <= 1'b1;
            ack_q  <= 4'b0001 << cur_id;
          end
`ifdef ES_CTRL_TIMEOUT_EN
          else begin
            to_cnt <= to_nxt;
            if (to_nxt == '1) begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
`endif
        end
        WR_WAIT: begin
          if (bus.out_ready[cur_id]) begin
            state  <= DONE;
            done_q <= 1'b1;
            rwe_q  <= 4'b0001 << cur_id;
          end
`ifdef ES_CTRL_TIMEOUT_EN
          else begin
            to_cnt <= to_nxt;
            if (to_nxt == '1) begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
`endif
        end
        default: begin
          state <= IDLE;
          // Timed-out reads leave the round-robin pointer alone.
          if (is_rd && !err_q) rr <= cur_id + 2'd1;
        end
      endcase
    end
  end

  assign bus.in_ack  = ack_q;
  assign bus.rwe     = rwe_q;
  assign bus.id_in   = id_q;
  assign bus.id_out  = id_q;
  assign bus.io_done = done_q;
  assign bus.pend    = pend_q;
  assign bus.pend_id = pend_id_q;
  assign bus.stall   = (bus.io_rd | bus.io_wr) & ~done_q;
`ifdef ES_CTRL_TIMEOUT_EN
  assign bus.io_err  = err_q;
`else
  assign bus.io_err  = 1'b0;
`endif

endmodule

// File: tb/tb_es_ctrl.sv
// Directed self-checking bench for es_ctrl; timeout case runs when ES_CTRL_TIMEOUT_EN is defined.
module tb_es_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  es_ctrl_if bus ();

  es_ctrl #(.TIMEOUT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs;
    bus.io_rd = 1'b0;
    bus.io_wr = 1'b0;
    bus.io_id = 2'd0;
    bus.in_valid = 4'd0;
    bus.out_ready = 4'd0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Read one port with its in_valid already set; returns two cycles after DONE.
  task automatic do_read(input logic [1:0] id);
    int n;
    bus.io_rd = 1'b1;
    bus.io_id = id;
    n = 0;
    while (!bus.io_done && n < 20) begin
      tick;
      n++;
    end
    check_eq("rd_done", 32'(bus.io_done), 32'd1);
    check_eq("rd_ack", 32'(bus.in_ack), 32'(4'b0001 << id));
    bus.io_rd = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // reset state
    check_eq("rst_ack", 32'(bus.in_ack), 32'd0);
    check_eq("rst_rwe", 32'(bus.rwe), 32'd0);
    check_eq("rst_ids", 32'({bus.id_in, bus.id_out}), 32'd0);
    check_eq("rst_done", 32'({bus.io_done, bus.io_err, bus.stall}), 32'd0);
    check_eq("rst_pend", 32'({bus.pend, bus.pend_id}), 32'd0);

    // write port 2, ready already true
    bus.io_wr = 1'b1; bus.io_id = 2'd2; bus.out_ready = 4'b0100;
    #1;
    check_eq("wr_c0_stall", 32'(bus.stall), 32'd1);
    tick;
    check_eq("wr_c1_idout", 32'(bus.id_out), 32'd2);
    check_eq("wr_c1_stall", 32'(bus.stall), 32'd1);
    check_eq("wr_c1_rwe", 32'(bus.rwe), 32'd0);
    check_eq("wr_c1_done", 32'(bus.io_done), 32'd0);
    tick;
    check_eq("wr_c2_rwe", 32'(bus.rwe), 32'b0100);
    check_eq("wr_c2_done", 32'(bus.io_done), 32'd1);
    check_eq("wr_c2_stall", 32'(bus.stall), 32'd0);
    check_eq("wr_c2_ack", 32'(bus.in_ack), 32'd0);
    check_eq("wr_c2_err", 32'(bus.io_err), 32'd0);
    idle_inputs();
    tick;
    check_eq("wr_c3_rwe", 32'(bus.rwe), 32'd0);
    check_eq("wr_c3_done", 32'(bus.io_done), 32'd0);

    // read port 1, valid rises in cycle 5; io_id changes mid-wait
    bus.io_rd = 1'b1; bus.io_id = 2'd1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      tick;
      check_eq($sformatf("rd_c%0d_idin", cyc), 32'(bus.id_in), 32'd1);
      check_eq($sformatf("rd_c%0d_done", cyc), 32'(bus.io_done), 32'd0);
      check_eq($sformatf("rd_c%0d_stall", cyc), 32'(bus.stall), 32'd1);
      if (cyc == 2) bus.io_id = 2'd3;
      if (cyc == 5) bus.in_valid = 4'b0010;
    end
    tick;
    check_eq("rd_c6_ack", 32'(bus.in_ack), 32'b0010);
    check_eq("rd_c6_done", 32'(bus.io_done), 32'd1);
    check_eq("rd_c6_idin", 32'(bus.id_in), 32'd1);
    check_eq("rd_c6_rwe", 32'(bus.rwe), 32'd0);
    idle_inputs();
    tick;
    check_eq("rd_c7_ack", 32'(bus.in_ack), 32'd0);

    // read beats write on port 3
    bus.io_rd = 1'b1; bus.io_wr = 1'b1; bus.io_id = 2'd3;
    bus.in_valid = 4'b1000; bus.out_ready = 4'b1111;
    tick;
    tick;
    check_eq("rw_ack", 32'(bus.in_ack), 32'b1000);
    check_eq("rw_rwe", 32'(bus.rwe), 32'd0);
    check_eq("rw_done", 32'(bus.io_done), 32'd1);
    idle_inputs();
    tick;
    check_eq("rw_after_rwe", 32'(bus.rwe), 32'd0);

    // round robin over in_valid = 1011
    do_reset();
    bus.in_valid = 4'b1011;
    tick;
    check_eq("rr_pend", 32'(bus.pend), 32'd1);
    check_eq("rr_first", 32'(bus.pend_id), 32'd0);
    do_read(2'd0);
    check_eq("rr_after0", 32'(bus.pend_id), 32'd1);
    do_read(2'd1);
    check_eq("rr_after1", 32'(bus.pend_id), 32'd3);
    do_read(2'd3);
    check_eq("rr_wrap", 32'(bus.pend_id), 32'd0);
    bus.in_valid = 4'd0;
    tick;
    tick;
    check_eq("rr_nopend", 32'(bus.pend), 32'd0);

    // reset during WR_WAIT port 0
    bus.io_wr = 1'b1; bus.io_id = 2'd0;
    tick;
    reset = 1'b1; bus.out_ready = 4'b0001;
    tick;
    check_eq("rstw_rwe", 32'(bus.rwe), 32'd0);
    check_eq("rstw_done", 32'(bus.io_done), 32'd0);
    check_eq("rstw_stall", 32'(bus.stall), 32'd1);
    reset = 1'b0; bus.io_wr = 1'b0;
    tick;
    check_eq("rstw_idle_rwe", 32'(bus.rwe), 32'd0);
    tick;
    check_eq("rstw_idle_done", 32'(bus.io_done), 32'd0);
    check_eq("rstw_idle_rwe2", 32'(bus.rwe), 32'd0);

    // reset during RD_WAIT port 2
    idle_inputs();
    bus.io_rd = 1'b1; bus.io_id = 2'd2;
    tick;
    check_eq("rstr_idin", 32'(bus.id_in), 32'd2);
    reset = 1'b1; bus.in_valid = 4'b0100;
    tick;
    check_eq("rstr_idin0", 32'(bus.id_in), 32'd0);
    check_eq("rstr_ack", 32'(bus.in_ack), 32'd0);
    check_eq("rstr_done", 32'(bus.io_done), 32'd0);
    check_eq("rstr_pend", 32'(bus.pend), 32'd0);
    reset = 1'b0;
    idle_inputs();
    tick;
    check_eq("rstr_idle_ack", 32'(bus.in_ack), 32'd0);

`ifdef ES_CTRL_TIMEOUT_EN
    begin
      int n;
      do_reset();
      bus.io_rd = 1'b1; bus.io_id = 2'd2;
      tick;
      n = 1;
      while (!bus.io_done && n < 40) begin
        tick;
        n++;
      end
      check_eq("to_waits", 32'(n - 1), 32'd15);
      check_eq("to_err", 32'(bus.io_err), 32'd1);
      check_eq("to_ack", 32'(bus.in_ack), 32'd0);
      idle_inputs();
      bus.in_valid = 4'b0001;
      tick;
      tick;
      check_eq("to_rr", 32'(bus.pend_id), 32'd0);
      idle_inputs();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/es_ctrl.md
# es_ctrl

I/O transfer controller that sequences the 4-in/4-out I/O block of the CPU. It takes single-port read/write requests from the control unit, drives the input-mux select, the output-mux select and the one-hot output-register write enables, and performs a valid/ready handshake with each peripheral. It stalls the CPU until each transfer completes. It also publishes a round-robin "next pending input" hint that software can poll.

## Interface
Parameters:
- TIMEOUT_W, 8, width of the handshake timeout counter; used only with the timeout feature.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- io_rd  in  1  CPU read request from input port io_id; held until io_done
- io_wr  in  1  CPU write request to output port io_id; held until io_done
- io_id  in  2  target port, 0..3
- in_valid  in  4  bit N: peripheral N is presenting data on input N
- out_ready  in  4  bit N: output N may be overwritten
- in_ack  out  4  one-hot 1-cycle pulse: input N consumed
- id_in  out  2  input-mux select
- id_out  out  2  output-mux select
- rwe  out  4  one-hot output-register write enables (bit N → register N)
- stall  out  1  CPU hold
- io_done  out  1  1-cycle transfer-complete pulse; CPU captures data_in on this cycle
- io_err  out  1  1-cycle pulse coincident with io_done on timeout
- pend  out  1  registered: some in_valid bit is set
- pend_id  out  2  registered: round-robin choice among pending inputs

## Operation
The FSM has four states: IDLE, RD_WAIT, WR_WAIT and DONE. The reset state is IDLE.

- **IDLE**
  - If io_rd is high: latch io_id into cur_id and go to RD_WAIT.
  - Else if io_wr is high: latch io_id into cur_id and go to WR_WAIT.
  - Read has priority over write when both are high.
- **RD_WAIT:** when in_valid[cur_id] is high, go to DONE.
- **WR_WAIT:** when out_ready[cur_id] is high, go to DONE.
- **DONE:** io_done = 1. Then return to IDLE.
  - Read transfer: in_ack[cur_id] = 1. The peripheral holds its data through this cycle.
  - Write transfer: rwe[cur_id] = 1, so the output register loads at the end of DONE.
- **Selects:** id_in and id_out both equal cur_id, registered. They are stable from the first wait cycle through DONE.
- **stall:** stall = (io_rd | io_wr) & ~io_done. Consequences:
  - A request present in IDLE stalls the CPU that same cycle.
  - A request still present in the IDLE cycle after DONE starts a new transfer.
- **Round-robin hint**
  - A 2-bit pointer rr resets to 0.
  - pend_id is the first set bit of in_valid, scanning rr, rr+1, … modulo 4.
  - pend = |in_valid.
  - Both pend and pend_id are registered, so they lag in_valid by 1 cycle.
  - On every successful read DONE, rr ← cur_id + 1 (mod 4). This wraps 3 → 0.
- **Exclusivity:** at most one bit of rwe | in_ack is ever high. Both are 0 outside DONE.

## Timing
- **Reset values** (any cycle, including mid-transfer): state = IDLE, cur_id = 0, rr = 0, timeout counter = 0.
  - All outputs are 0, except that stall follows its combinational equation.
  - No rwe or in_ack pulse is emitted for an aborted transfer.
- **Minimum latency:** request in cycle 0 → wait state in cycle 1 → DONE in cycle 2 if the handshake is already true. That is 3 stall-inclusive cycles, with io_done in cycle 2.
- **Handshake sampling:** in_valid and out_ready are sampled only in the wait states. A ready/valid that drops before being sampled is ignored.
- **Ignored inputs:** changes to io_id after the request is latched are ignored.

## Configuration
- **ES_CTRL_TIMEOUT_EN defined**
  - A TIMEOUT_W-bit counter clears on entry to RD_WAIT/WR_WAIT and increments on each wait cycle.
  - When it reaches 2^TIMEOUT_W − 1 with the handshake still false, the FSM goes to DONE with io_done = 1 and io_err = 1.
  - On a timeout DONE: no rwe, no in_ack, rr unchanged.
- **ES_CTRL_TIMEOUT_EN undefined**
  - The wait states wait indefinitely.
  - io_err is tied to 0 and no counter logic exists.

## Test plan
- Write, port 2 ready: io_wr = 1, io_id = 2, out_ready = 4'b0100 → id_out = 2 from cycle 1; rwe = 4'b0100 and io_done in cycle 2 only; stall high in cycles 0–1, low in cycle 2.
- Read, delayed valid: io_rd = 1, io_id = 1, in_valid[1] rises in cycle 5 → DONE in cycle 6 with in_ack = 4'b0010 and io_done; id_in = 1 throughout.
- Read beats write: io_rd = io_wr = 1, io_id = 3, in_valid = 4'b1000 → read path taken, in_ack = 4'b1000, rwe stays 0.
- Round robin: in_valid = 4'b1011, rr = 0 → pend_id = 0. After reading port 0: pend_id = 1. After reading port 1: pend_id = 3. After reading port 3: rr = 0 (wrap).
- Reset mid-transfer: reset asserted in WR_WAIT for port 0, then out_ready = 1 → no rwe pulse, FSM in IDLE, all outputs 0 on the next edge.
- With ES_CTRL_TIMEOUT_EN and TIMEOUT_W = 4: read port 2, in_valid = 0 → io_done = io_err = 1 after 15 wait cycles, in_ack = 0, rr unchanged.
